lcd_hd44780_ctrl: RTL and testbench
===================================

Name: lcd_hd44780_ctrl

Overview:
Parametrised HD44780 character-LCD controller driving the 4-bit SF_D bus (lcd_d, lcd_e, lcd_rs, lcd_rw). It runs the power-on init sequence and a configurable display-configuration sequence autonomously, then accepts arbitrary command/data bytes over a valid/ready handshake, so text, DDRAM/CGRAM addressing and custom glyphs come from upstream logic instead of hard-coded tables. Every timing interval is a parameter, so benches can shrink delays and other clock rates are supported.

Parameters:
T_POWERUP, 750000, cycles waited after reset before the first init nibble (15 ms @ 50 MHz)
T_INIT2, 205000, wait after the 1st 0x3 nibble (4.1 ms)
T_INIT3, 5000, wait after the 2nd 0x3 nibble (100 us)
T_INIT4, 2000, wait after the 3rd 0x3 nibble and after the 0x2 nibble (40 us)
T_SETUP, 2, cycles lcd_d/lcd_rs are stable with lcd_e=0 before and after each E pulse
E_PULSE, 12, cycles lcd_e is high per nibble
T_NIBBLE, 50, gap between the upper and lower nibble of one byte (1 us)
T_CMD, 2000, post-byte wait for normal commands and data (40 us)
T_CLEAR, 82000, post-byte wait for Clear Display / Return Home (1.64 ms)
CFG_FUNC, 8'h28, function-set byte sent first in config
CFG_ENTRY, 8'h06, entry-mode byte
CFG_DISPLAY, 8'h0C, display-control byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  upstream has a byte to send
req_ready  out  1  controller accepts a byte this cycle
req_rs  in  1  0 = command, 1 = data (DDRAM/CGRAM write)
req_data  in  8  byte to send
init_done  out  1  power init and config complete; sticky until rst
busy  out  1  high whenever the FSM is not in IDLE
lcd_d  out  4  LCD data nibble (SF_D<11:8>)
lcd_e  out  1  LCD enable
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; tied 0 (write-only)

Behaviour:
- Reset: rst is sampled on posedge clk. When asserted: lcd_d=0, lcd_e=0, lcd_rs=0, lcd_rw=0, req_ready=0, init_done=0, busy=1, FSM goes to PWR_WAIT with counter=T_POWERUP. Reset mid-transfer aborts immediately (lcd_e drops in the cycle after rst is sampled) and the full init restarts.
- Phase timing: a phase parameterised N lasts exactly N clock cycles. All parameters are >=1. Counter width is clog2(max parameter + 1).
- Nibble transfer NIB(x, rs): SETUP for T_SETUP cycles (lcd_d=x, lcd_rs=rs, lcd_e=0), then PULSE for E_PULSE cycles (lcd_e=1, d/rs unchanged), then HOLD for T_SETUP cycles (lcd_e=0, d/rs unchanged). lcd_d and lcd_rs keep their last values between transfers.
- Byte transfer BYTE(b, rs): NIB(b[7:4], rs), then GAP for T_NIBBLE cycles, then NIB(b[3:0], rs), then WAIT for Tw cycles.
  - Tw = T_CLEAR if rs=0 and b is 8'h01, 8'h02 or 8'h03.
  - Tw = T_CMD otherwise.
- Power-init states, all with rs=0:
  - PWR_WAIT(T_POWERUP)
  - NIB(3), wait T_INIT2
  - NIB(3), wait T_INIT3
  - NIB(3), wait T_INIT4
  - NIB(2), wait T_INIT4
- Config states: BYTE(CFG_FUNC,0), BYTE(CFG_ENTRY,0), BYTE(CFG_DISPLAY,0), BYTE(8'h01,0) with a T_CLEAR wait, then IDLE. init_done rises in the first IDLE cycle.
- IDLE: req_ready=1 and busy=0.
  - Accept on the edge where req_valid && req_ready; req_rs and req_data are latched.
  - From the next cycle, req_ready=0 and busy=1 while BYTE(req_data, req_rs) runs.
  - req_ready returns high in the first cycle after WAIT ends. Latency from acceptance edge to req_ready high is 4*T_SETUP + 2*E_PULSE + T_NIBBLE + Tw + 1 cycles.
- req_valid while req_ready=0 (init or a transfer in progress) is ignored: nothing is queued, and upstream must hold the request. Changing req_data/req_rs after acceptance has no effect on the transfer.
- Back-to-back: if req_valid is held, the next byte is accepted on the first IDLE edge, so there are no extra idle cycles.
- lcd_e is never high outside PULSE. lcd_d and lcd_rs never change while lcd_e=1.

Test Plan:
1. Shrunk timings (T_POWERUP=20, T_INIT2=10, T_INIT3=6, T_INIT4=4, T_SETUP=2, E_PULSE=4, T_NIBBLE=3, T_CMD=10, T_CLEAR=20), rst for 3 cycles -> E-pulse nibbles 3,3,3,2 then 2,8,0,6,0,C,0,1, all with rs=0; gaps match the parameters; init_done=1 and req_ready=1 afterwards.
2. After init, req_rs=1, req_data=8'h53 accepted -> nibbles 5 then 3 with lcd_rs=1, each E pulse 4 cycles wide; req_ready low for 8+8+3+10=29 cycles, high at acceptance+30.
3. Command 8'h01 then 8'hC0 with req_valid held -> 01 uses a 20-cycle wait and C0 a 10-cycle wait; C0 is accepted in the first IDLE cycle after 01 completes.
4. CGRAM glyph: 8'h40 (rs=0) then eight data bytes 0E,0A,0E,04,1F,04,0A,1B -> nine transfers in order, rs pattern 0 then 1 x8, nothing dropped or duplicated.
5. req_valid pulsed during init and mid-transfer -> no extra transfer appears on lcd_*, and the latched byte is unchanged.
6. rst asserted during the PULSE of a data nibble -> lcd_e=0 the next cycle, all outputs at reset values, init restarts from PWR_WAIT, and init_done stays 0 until config completes again.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit controller: power-on init, configuration bytes, then
// command/data bytes accepted over a valid/ready handshake.
module lcd_hd44780_ctrl #(
  parameter int          T_POWERUP   = 750000,
  parameter int          T_INIT2     = 205000,
  parameter int          T_INIT3     = 5000,
  parameter int          T_INIT4     = 2000,
  parameter int          T_SETUP     = 2,
  parameter int          E_PULSE     = 12,
  parameter int          T_NIBBLE    = 50,
  parameter int          T_CMD       = 2000,
  parameter int          T_CLEAR     = 82000,
  parameter logic [7:0]  CFG_FUNC    = 8'h28,
  parameter logic [7:0]  CFG_ENTRY   = 8'h06,
  parameter logic [7:0]  CFG_DISPLAY = 8'h0C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(T_POWERUP, T_INIT2), max2(T_INIT3, T_INIT4)),
                             max2(max2(T_SETUP, E_PULSE), max2(max2(T_NIBBLE, T_CMD), T_CLEAR)));
  localparam int CW = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_PWR, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_WAIT, S_IDLE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;     // 0-3 init nibbles, 4-7 config bytes, 8 upstream
  logic          half, half_n;
  logic [7:0]    byte_q, byte_n;
  logic          rs_q, rs_n;
  logic [3:0]    d_q, d_n;
  logic          lrs_q, lrs_n;
  logic          done_q, done_n;

  logic          last, start, start_rs, start_half;
  logic [7:0]    start_b;

  // Init nibbles are carried in the upper half of a byte and sent as half 0.
  function automatic logic [7:0] step_byte(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2: return 8'h30;
      4'd3:             return 8'h20;
      4'd4:             return CFG_FUNC;
      4'd5:             return CFG_ENTRY;
      4'd6:             return CFG_DISPLAY;
      default:          return 8'h01;
    endcase
  endfunction

  function automatic logic [CW-1:0] init_wait(input logic [3:0] i);
    case (i)
      4'd0:    return CW'(T_INIT2);
      4'd1:    return CW'(T_INIT3);
      default: return CW'(T_INIT4);
    endcase
  endfunction

  function automatic logic [CW-1:0] byte_wait(input logic [7:0] b, input logic rs);
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return CW'(T_CLEAR);
    return CW'(T_CMD);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_PWR;
      cnt    <= CW'(T_POWERUP);
      idx    <= '0;
      half   <= 1'b0;
      byte_q <= '0;
      rs_q   <= 1'b0;
      d_q    <= '0;
      lrs_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      half   <= half_n;
      byte_q <= byte_n;
      rs_q   <= rs_n;
      d_q    <= d_n;
      lrs_q  <= lrs_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt - 1'b1;
    idx_n      = idx;
    half_n     = half;
    byte_n     = byte_q;
    rs_n       = rs_q;
    d_n        = d_q;
    lrs_n      = lrs_q;
    start      = 1'b0;
    start_b    = byte_q;
    start_rs   = rs_q;
    start_half = 1'b0;
    last       = (cnt == CW'(1));

    case (state)
      S_PWR: if (last) begin
        idx_n   = 4'd0;
        start   = 1'b1;
        start_b = step_byte(4'd0);
        start_rs = 1'b0;
      end
      S_SETUP: if (last) begin
        state_n = S_PULSE;
        cnt_n   = CW'(E_PULSE);
      end
      S_PULSE: if (last) begin
        state_n = S_HOLD;
        cnt_n   = CW'(T_SETUP);
      end
      S_HOLD: if (last) begin
        if (idx < 4'd4) begin
          state_n = S_WAIT;
          cnt_n   = init_wait(idx);
        end else if (!half) begin
          state_n = S_GAP;
          cnt_n   = CW'(T_NIBBLE);
        end else begin
          state_n = S_WAIT;
          cnt_n   = byte_wait(byte_q, rs_q);
        end
      end
      S_GAP: if (last) begin
        start      = 1'b1;
        start_half = 1'b1;
      end
      S_WAIT: if (last) begin
        if (idx >= 4'd7) begin
          state_n = S_IDLE;
          idx_n   = 4'd8;
        end else begin
          idx_n    = idx + 4'd1;
          start    = 1'b1;
          start_b  = step_byte(idx + 4'd1);
          start_rs = 1'b0;
        end
      end
      S_IDLE: begin
        cnt_n = cnt;
        if (req_valid) begin
          start    = 1'b1;
          start_b  = req_data;
          start_rs = req_rs;
        end
      end
      default: begin
        state_n = S_PWR;
        cnt_n   = CW'(T_POWERUP);
      end
    endcase

    if (start) begin
      state_n = S_SETUP;
      cnt_n   = CW'(T_SETUP);
      byte_n  = start_b;
      rs_n    = start_rs;
      half_n  = start_half;
      d_n     = start_half ? start_b[3:0] : start_b[7:4];
      lrs_n   = start_rs;
    end

    done_n = done_q | (state_n == S_IDLE);
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign init_done = done_q;
  assign lcd_e     = (state == S_PULSE);
  assign lcd_d     = d_q;
  assign lcd_rs    = lrs_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected E-pulse nibbles and
// req_ready rise times are queued at stimulus time and popped by a monitor.
module tb_lcd_hd44780_ctrl;

  localparam int TP = 20, TI2 = 10, TI3 = 6, TI4 = 4, TS = 2, EP = 4, TN = 3, TC = 10, TCL = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = '0;
  logic       req_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  lcd_hd44780_ctrl #(
    .T_POWERUP(TP), .T_INIT2(TI2), .T_INIT3(TI3), .T_INIT4(TI4), .T_SETUP(TS),
    .E_PULSE(EP), .T_NIBBLE(TN), .T_CMD(TC), .T_CLEAR(TCL),
    .CFG_FUNC(8'h28), .CFG_ENTRY(8'h06), .CFG_DISPLAY(8'h0C)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_data(req_data), .init_done(init_done), .busy(busy),
    .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         t;
  } nib_t;

  nib_t exp_nib[$];
  int   ready_q[$];
  int   cyc = 0;
  int   init_idle = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tw(input logic [7:0] b, input logic rs);
    return (!rs && b >= 8'h01 && b <= 8'h03) ? TCL : TC;
  endfunction

  function automatic void push_nib(input logic rs, input logic [3:0] d, input int t);
    nib_t n;
    n.rs = rs; n.d = d; n.t = t;
    exp_nib.push_back(n);
  endfunction

  // Absolute E-rise times counted from the last edge that sampled rst.
  task automatic push_init();
    int         t;
    logic [3:0] nibs [4];
    int         waits [4];
    logic [7:0] cfg [4];
    nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
    waits = '{TI2, TI3, TI4, TI4};
    cfg   = '{8'h28, 8'h06, 8'h0C, 8'h01};
    t = TP + TS;
    for (int i = 0; i < 4; i++) begin
      push_nib(1'b0, nibs[i], t);
      t += EP + 2 * TS + waits[i];
    end
    for (int i = 0; i < 4; i++) begin
      push_nib(1'b0, cfg[i][7:4], t);
      t += EP + 2 * TS + TN;
      push_nib(1'b0, cfg[i][3:0], t);
      t += EP + 2 * TS + tw(cfg[i], 1'b0);
    end
    init_idle = t - TS;
    ready_q.push_back(init_idle);
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  initial begin
    logic       in_pulse, prev_ready, p_rs;
    logic [3:0] p_d;
    int         width;
    nib_t       e;
    in_pulse = 1'b0; prev_ready = 1'b0; width = 0; p_rs = 1'b0; p_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pulse = 1'b0;
        prev_ready = 1'b0;
      end else begin
        chk("rw_zero", lcd_rw, 0);
        chk("busy_vs_ready", busy, !req_ready);
        chk("init_done", init_done, cyc >= init_idle);
        if (lcd_e && !in_pulse) begin
          in_pulse = 1'b1; width = 1; p_d = lcd_d; p_rs = lcd_rs;
          if (exp_nib.size() == 0) chk("unexpected_pulse", lcd_d, -1);
          else begin
            e = exp_nib.pop_front();
            chk("nib_d", lcd_d, e.d);
            chk("nib_rs", lcd_rs, e.rs);
            chk("nib_time", cyc, e.t);
          end
        end else if (lcd_e) begin
          width++;
          if (lcd_d != p_d || lcd_rs != p_rs) chk("stable_in_pulse", {lcd_rs, lcd_d}, {p_rs, p_d});
        end else if (in_pulse) begin
          in_pulse = 1'b0;
          chk("pulse_width", width, EP);
        end
        if (req_ready && !prev_ready) begin
          if (ready_q.size() == 0) chk("unexpected_ready", cyc, -1);
          else chk("ready_time", cyc, ready_q.pop_front());
        end
        prev_ready = req_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset();
    chk("rst_lcd_d", lcd_d, 0);
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] b, input logic keep);
    int n, a;
    req_valid = 1'b1; req_rs = rs; req_data = b;
    n = 0;
    while (!req_ready && n < 3000) begin tick(); n++; end
    if (!req_ready) begin
      chk("send_timeout", n, -1);
      req_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    push_nib(rs, b[7:4], a + TS);
    push_nib(rs, b[3:0], a + 3 * TS + EP + TN);
    ready_q.push_back(a + 4 * TS + 2 * EP + TN + tw(b, rs));
    tick();
    if (!keep) begin
      req_valid = 1'b0;
      req_data  = 8'($urandom);
      req_rs    = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(req_ready && exp_nib.size() == 0 && ready_q.size() == 0) && n < 3000) begin
      tick(); n++;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
  endtask

  initial begin
    logic [7:0] glyph [8];
    int         n;
    logic       keep;
    glyph = '{8'h0E, 8'h0A, 8'h0E, 8'h04, 8'h1F, 8'h04, 8'h0A, 8'h1B};

    repeat (3) tick();
    chk_reset();
    push_init();
    rst = 1'b0;

    // valid pulsed during init must be ignored
    repeat (10) tick();
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'hEE;
    tick();
    req_valid = 1'b0;
    wait_idle();
    chk("init_done_after_init", init_done, 1);

    send(1'b1, 8'h53, 1'b0);
    wait_idle();

    send(1'b0, 8'h01, 1'b1);
    send(1'b0, 8'hC0, 1'b0);
    wait_idle();

    send(1'b0, 8'h40, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, glyph[i], i != 7);
    wait_idle();

    // valid pulsed mid-transfer with other data must not disturb the latched byte
    send(1'b1, 8'hA5, 1'b0);
    repeat (5) tick();
    req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h01;
    tick();
    req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      logic       rs;
      logic [7:0] b;
      rs   = 1'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      keep = (i != 19) && ($urandom_range(0, 1) == 1);
      send(rs, b, keep);
      if (!keep) repeat ($urandom_range(0, 5)) tick();
    end
    wait_idle();

    // reset during the E pulse of a data nibble
    send(1'b1, 8'h77, 1'b0);
    n = 0;
    while (!lcd_e && n < 100) begin tick(); n++; end
    chk("saw_data_pulse", lcd_e, 1);
    rst = 1'b1;
    exp_nib.delete();
    ready_q.delete();
    tick();
    chk_reset();
    repeat (2) tick();
    push_init();
    rst = 1'b0;
    tick();
    chk("init_done_low_after_abort", init_done, 0);
    wait_idle();
    send(1'b1, 8'h21, 1'b0);
    wait_idle();

    chk("nib_queue_empty", exp_nib.size(), 0);
    chk("ready_queue_empty", ready_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
